cmos_frame_ctrl: RTL and testbench
==================================

# cmos_frame_ctrl

Frame-capture sequencer for the OV5640 pixel path. It waits out the sensor settle frames after capture is enabled, then opens the byte-valid gate into the 8-to-16-bit pixel packer on frame boundaries only. While capturing, it counts packed pixels and lines and reports frame start, frame done and frame-geometry errors to the frame-buffer writer. It sits between the camera sync pins and the packer's `de_i` input, and observes the packer's pixel strobe and line-valid outputs.

## Interface
Parameters:
- SKIP_FRAMES, 10, complete frames discarded after capture_en rises (0 = none)
- H_ACT, 640, expected 16-bit pixels per line
- V_ACT, 480, expected lines per frame

Ports:
- pclk  in  1  camera pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- capture_en  in  1  level; 1 = capture frames continuously
- vsync_i  in  1  camera VSYNC, high between frames
- href_i  in  1  camera HREF, byte-valid
- pix_de_i  in  1  packer 16-bit pixel strobe
- line_i  in  1  packer line-valid (HREF delayed one cycle)
- de_gate_o  out  1  gated HREF driven to the packer de_i
- frame_start_o  out  1  one-cycle pulse, capture of a frame begins
- frame_done_o  out  1  one-cycle pulse, captured frame ended
- frame_err_o  out  1  one-cycle pulse coincident with frame_done_o when geometry mismatched
- busy_o  out  1  high in WAIT or CAPTURE
- x_cnt_o  out  12  pixels in current line
- y_cnt_o  out  12  completed lines in current/last frame
- frame_cnt_o  out  8  captured frames, wraps 255->0

## Operation
- Edge detection:
  - vsync_d and line_d are registered copies of vsync_i and line_i.
  - vs_rise = vsync_i & ~vsync_d.
  - vs_fall = ~vsync_i & vsync_d.
  - line_end = ~line_i & line_d.
- States: IDLE, WAIT, CAPTURE.
- IDLE:
  - capture_en=1 -> WAIT, with skip_cnt=0.
- WAIT:
  - capture_en=0 -> IDLE. This has priority over any vsync edge.
  - On vs_fall with skip_cnt==SKIP_FRAMES -> CAPTURE, pulse frame_start_o, clear x_cnt, y_cnt and line_err.
  - On vs_fall otherwise, skip_cnt++.
- CAPTURE:
  - de_gate_o = href_i & (state==CAPTURE). This is combinational; all other outputs are registered.
  - x_cnt increments on pix_de_i, saturating at 4095.
  - On line_end:
    - y_cnt++ (saturating at 4095).
    - x_cnt clears to 0.
    - line_err is set if the final line length != H_ACT. The final length includes a pix_de_i in the same cycle (x_cnt+1).
  - On vs_rise:
    - Pulse frame_done_o.
    - Pulse frame_err_o = line_err | (y_cnt != V_ACT) | (x_cnt != 0).
    - frame_cnt++.
    - Next state: WAIT with skip_cnt=SKIP_FRAMES if capture_en=1 (no re-skip for back-to-back frames), else IDLE.
  - capture_en=0 during CAPTURE does not abort; the frame completes first.
- y_cnt_o holds the final line count after frame_done_o until the next frame_start_o.
- skip_cnt is 8 bits wide; SKIP_FRAMES must be <= 255.
- HREF activity outside CAPTURE never reaches the packer and never touches the counters.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0.
  - de_gate_o = 0.
  - skip_cnt, vsync_d, line_d and line_err all 0.
- frame_start_o is high in the cycle after the cycle in which vs_fall is true. The state is CAPTURE from that same cycle.
- frame_done_o / frame_err_o are high in the cycle after the vs_rise cycle. State has left CAPTURE in that cycle.
- x_cnt_o / y_cnt_o update one cycle after pix_de_i / line_end.
- de_gate_o follows href_i with zero latency while in CAPTURE.
- Simultaneous pix_de_i and line_end: the pixel is counted toward the line check, and x_cnt ends at 0.
- An asynchronous rst mid-frame forces IDLE immediately. The next capture re-skips SKIP_FRAMES frames.

## Test plan
- SKIP_FRAMES=2, H_ACT=4, V_ACT=3, capture_en=1, then 3 frames of 3 lines x 8 bytes:
  - Frames 1-2 produce no de_gate_o.
  - frame_start_o appears once, at the third vs_fall.
  - frame_done_o appears with frame_err_o=0, y_cnt_o=3, frame_cnt_o=1.
- Continuous capture, 2 more frames after the first: frame_start_o occurs at each following vs_fall with no skip, and frame_cnt_o reaches 3.
- One line carries 6 bytes (3 pixels): frame_done_o is accompanied by frame_err_o=1, and the next correct frame gives frame_err_o=0.
- capture_en dropped mid-CAPTURE: the frame completes with frame_done_o, the block goes to IDLE with busy_o=0, and later frames produce no de_gate_o.
- rst asserted mid-line: all outputs are 0 immediately. Re-enabling skips 2 frames again.
- SKIP_FRAMES=0, enable asserted during VSYNC high: capture starts at that VSYNC's falling edge.

Source files
------------

// File: rtl/cmos_frame_ctrl.sv
// OV5640 frame-capture sequencer: skips settle frames, gates HREF into the pixel
// packer on frame boundaries, and checks captured frame geometry.
module cmos_frame_ctrl #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        capture_en,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic        pix_de_i,
    input  logic        line_i,
    output logic        de_gate_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic        busy_o,
    output logic [11:0] x_cnt_o,
    output logic [11:0] y_cnt_o,
    output logic [7:0]  frame_cnt_o
);

    localparam logic [7:0]  SKIP_LIM = 8'(SKIP_FRAMES);
    localparam logic [12:0] H_LEN    = 13'(H_ACT);
    localparam logic [11:0] V_LEN    = 12'(V_ACT);
    localparam logic [11:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  skip_cnt;
    logic [7:0]  skip_nxt;
    logic        vsync_d;
    logic        line_d;
    logic        line_err;
    logic        vs_rise;
    logic        vs_fall;
    logic        line_end;
    logic        capturing;
    logic        start_hit;
    logic        done_hit;
    logic [12:0] line_len;

    assign vs_rise  = vsync_i & ~vsync_d;
    assign vs_fall  = ~vsync_i & vsync_d;
    assign line_end = ~line_i & line_d;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Disable in WAIT wins over any VSYNC edge; in CAPTURE the frame always finishes.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        case (state)
            IDLE: begin
                if (capture_en) begin
                    state_nxt = WAIT;
                    skip_nxt  = '0;
                end
            end
            WAIT: begin
                if (!capture_en) begin
                    state_nxt = IDLE;
                end else if (vs_fall) begin
                    if (skip_cnt == SKIP_LIM) state_nxt = CAPTURE;
                    else                      skip_nxt  = skip_cnt + 8'd1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    state_nxt = capture_en ? WAIT : IDLE;
                    skip_nxt  = SKIP_LIM;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capturing = (state == CAPTURE);
        start_hit = (state == WAIT) && capture_en && vs_fall && (skip_cnt == SKIP_LIM);
        done_hit  = capturing && vs_rise;
        de_gate_o = href_i & capturing;
        line_len  = {1'b0, x_cnt_o} + {12'd0, pix_de_i};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_d       <= 1'b0;
            line_d        <= 1'b0;
            line_err      <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            busy_o        <= 1'b0;
            x_cnt_o       <= '0;
            y_cnt_o       <= '0;
            frame_cnt_o   <= '0;
        end else begin
            vsync_d       <= vsync_i;
            line_d        <= line_i;
            frame_start_o <= start_hit;
            frame_done_o  <= done_hit;
            frame_err_o   <= done_hit & (line_err | (y_cnt_o != V_LEN) | (x_cnt_o != 12'd0));
            busy_o        <= (state_nxt != IDLE);
            if (done_hit) frame_cnt_o <= frame_cnt_o + 8'd1;
            if (start_hit) begin
                x_cnt_o  <= '0;
                y_cnt_o  <= '0;
                line_err <= 1'b0;
            end else if (capturing) begin
                // A pixel landing on the line-end cycle still counts toward the length check.
                if (line_end) begin
                    x_cnt_o <= '0;
                    if (y_cnt_o != CNT_MAX) y_cnt_o <= y_cnt_o + 12'd1;
                    if (line_len != H_LEN) line_err <= 1'b1;
                end else if (pix_de_i && (x_cnt_o != CNT_MAX)) begin
                    x_cnt_o <= x_cnt_o + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_frame_ctrl.sv
// Directed bench for cmos_frame_ctrl: frame-table vectors plus hand sequences for
// reset mid-line, coincident pixel/line-end, counter saturation and zero-skip start.
module tb_cmos_frame_ctrl;

    logic pclk = 1'b0;
    logic rst;
    logic capture_en, capture_en0;
    logic vsync_i, href_i, pix_de_i, line_i;
    logic de_gate_o, frame_start_o, frame_done_o, frame_err_o, busy_o;
    logic [11:0] x_cnt_o, y_cnt_o;
    logic [7:0]  frame_cnt_o;
    logic de_gate_z, frame_start_z, frame_done_z, frame_err_z, busy_z;
    logic [11:0] x_cnt_z, y_cnt_z;
    logic [7:0]  frame_cnt_z;

    always #5 pclk = ~pclk;

    cmos_frame_ctrl #(.SKIP_FRAMES(2), .H_ACT(4), .V_ACT(3)) dut (
        .pclk(pclk), .rst(rst), .capture_en(capture_en), .vsync_i(vsync_i),
        .href_i(href_i), .pix_de_i(pix_de_i), .line_i(line_i),
        .de_gate_o(de_gate_o), .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
        .frame_err_o(frame_err_o), .busy_o(busy_o), .x_cnt_o(x_cnt_o),
        .y_cnt_o(y_cnt_o), .frame_cnt_o(frame_cnt_o)
    );

    cmos_frame_ctrl #(.SKIP_FRAMES(0), .H_ACT(4), .V_ACT(3)) dut0 (
        .pclk(pclk), .rst(rst), .capture_en(capture_en0), .vsync_i(vsync_i),
        .href_i(href_i), .pix_de_i(pix_de_i), .line_i(line_i),
        .de_gate_o(de_gate_z), .frame_start_o(frame_start_z), .frame_done_o(frame_done_z),
        .frame_err_o(frame_err_z), .busy_o(busy_z), .x_cnt_o(x_cnt_z),
        .y_cnt_o(y_cnt_z), .frame_cnt_o(frame_cnt_z)
    );

    typedef struct {
        logic        en;
        logic        en_mid;
        int          lines;
        int          bad;
        int          s;
        int          d;
        int          e;
        logic [11:0] y_done;
        logic [7:0]  f_done;
        int          gate_n;
        logic        busy;
        logic [11:0] y_end;
    } vec_t;

    vec_t tbl[11];

    int n_chk = 0;
    int n_fail = 0;
    int n_start, n_done, n_err, n_gate;
    int n_start0, n_done0, n_err0;
    logic [11:0] done_y, done_y0;
    logic [7:0]  done_f, done_f0;
    logic pk_line, pk_odd;
    int   pk_idx;

    function automatic vec_t mk(logic en, logic en_mid, int lines, int bad, int s, int d,
                                int e, int y_done, int f_done, int gate_n, logic busy,
                                int y_end);
        vec_t v;
        v.en = en; v.en_mid = en_mid; v.lines = lines; v.bad = bad;
        v.s = s; v.d = d; v.e = e;
        v.y_done = 12'(y_done); v.f_done = 8'(f_done);
        v.gate_n = gate_n; v.busy = busy; v.y_end = 12'(y_end);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_start = 0; n_done = 0; n_err = 0; n_gate = 0;
        n_start0 = 0; n_done0 = 0; n_err0 = 0;
        done_y = '0; done_f = '0; done_y0 = '0; done_f0 = '0;
    endtask

    // One pclk cycle of raw pin values; outputs are logged at the falling edge.
    task automatic raw(input logic vs, input logic hr, input logic ln, input logic px);
        vsync_i = vs; href_i = hr; line_i = ln; pix_de_i = px;
        @(negedge pclk);
        if (frame_start_o) n_start++;
        if (frame_done_o) begin n_done++; done_y = y_cnt_o; done_f = frame_cnt_o; end
        if (frame_err_o) n_err++;
        if (de_gate_o) n_gate++;
        if (frame_start_z) n_start0++;
        if (frame_done_z) begin n_done0++; done_y0 = y_cnt_z; done_f0 = frame_cnt_z; end
        if (frame_err_z) n_err0++;
        @(posedge pclk);
        #1;
    endtask

    // Packer model: line follows HREF by one cycle, a pixel strobe follows every odd byte.
    task automatic step(input logic vs, input logic hr);
        raw(vs, hr, pk_line, pk_odd);
        pk_line = hr;
        if (hr) begin
            pk_odd = (pk_idx % 2 == 1);
            pk_idx++;
        end else begin
            pk_odd = 1'b0;
            pk_idx = 0;
        end
    endtask

    task automatic run_period(input logic en, input logic en_mid, input int lines, input int bad);
        capture_en = en;
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            if (l == 1) capture_en = en_mid;
            repeat ((l == 1) ? bad : 8) step(1'b0, 1'b1);
            repeat (3) step(1'b0, 1'b0);
        end
        repeat (4) step(1'b1, 1'b0);
    endtask

    task automatic coincident_line();
        raw(1'b0, 1'b1, 1'b0, 1'b0);
        raw(1'b0, 1'b1, 1'b1, 1'b0);
        raw(1'b0, 1'b1, 1'b1, 1'b1);
        raw(1'b0, 1'b1, 1'b1, 1'b1);
        raw(1'b0, 1'b0, 1'b1, 1'b1);
        raw(1'b0, 1'b0, 1'b0, 1'b1);
        raw(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            en mid ln bad  s d e  y f  gate busy yend
        tbl[0]  = mk(1, 1, 3, 8, 0, 0, 0, 0, 0, 0,  1, 0);
        tbl[1]  = mk(1, 1, 3, 8, 0, 0, 0, 0, 0, 0,  1, 0);
        tbl[2]  = mk(1, 1, 3, 8, 1, 1, 0, 3, 1, 24, 1, 3);
        tbl[3]  = mk(1, 1, 3, 8, 1, 1, 0, 3, 2, 24, 1, 3);
        tbl[4]  = mk(1, 1, 3, 8, 1, 1, 0, 3, 3, 24, 1, 3);
        tbl[5]  = mk(1, 1, 3, 6, 1, 1, 1, 3, 4, 22, 1, 3);
        tbl[6]  = mk(1, 1, 3, 8, 1, 1, 0, 3, 5, 24, 1, 3);
        tbl[7]  = mk(1, 1, 2, 8, 1, 1, 1, 2, 6, 16, 1, 2);
        tbl[8]  = mk(1, 1, 3, 8, 1, 1, 0, 3, 7, 24, 1, 3);
        tbl[9]  = mk(1, 0, 3, 8, 1, 1, 0, 3, 8, 24, 0, 3);
        tbl[10] = mk(0, 0, 3, 8, 0, 0, 0, 0, 0, 0,  0, 3);

        rst = 1'b1;
        capture_en = 1'b0; capture_en0 = 1'b0;
        vsync_i = 1'b0; href_i = 1'b0; pix_de_i = 1'b0; line_i = 1'b0;
        pk_line = 1'b0; pk_odd = 1'b0; pk_idx = 0;
        clear_log();

        // clock and reset
        #12;
        chk("rst_x", x_cnt_o, 0);
        chk("rst_y", y_cnt_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_start", frame_start_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err", frame_err_o, 0);
        chk("rst_gate", de_gate_o, 0);
        rst = 1'b0;
        @(posedge pclk);
        #1;
        repeat (3) step(1'b1, 1'b0);

        for (int i = 0; i < 11; i++) begin
            clear_log();
            run_period(tbl[i].en, tbl[i].en_mid, tbl[i].lines, tbl[i].bad);
            chk($sformatf("v%0d_start", i), n_start, tbl[i].s);
            chk($sformatf("v%0d_done", i), n_done, tbl[i].d);
            chk($sformatf("v%0d_err", i), n_err, tbl[i].e);
            chk($sformatf("v%0d_done_y", i), done_y, tbl[i].y_done);
            chk($sformatf("v%0d_done_fcnt", i), done_f, tbl[i].f_done);
            chk($sformatf("v%0d_gate", i), n_gate, tbl[i].gate_n);
            chk($sformatf("v%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("v%0d_y_end", i), y_cnt_o, tbl[i].y_end);
            chk($sformatf("v%0d_x_end", i), x_cnt_o, 0);
        end

        // async reset in the middle of a captured line
        clear_log();
        run_period(1'b1, 1'b1, 3, 8);
        run_period(1'b1, 1'b1, 3, 8);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        chk("pre_rst_start", n_start, 1);
        chk("pre_rst_x", x_cnt_o, 1);
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_gate", de_gate_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gate", de_gate_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_x", x_cnt_o, 0);
        chk("mid_rst_y", y_cnt_o, 0);
        chk("mid_rst_frame_cnt", frame_cnt_o, 0);
        chk("mid_rst_start", frame_start_o, 0);
        chk("mid_rst_done", frame_done_o, 0);
        chk("mid_rst_err", frame_err_o, 0);
        href_i = 1'b0;
        pk_line = 1'b0; pk_odd = 1'b0; pk_idx = 0;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b0);
        clear_log();
        run_period(1'b1, 1'b1, 3, 8);
        run_period(1'b1, 1'b1, 3, 8);
        chk("reskip_start", n_start, 0);
        chk("reskip_gate", n_gate, 0);
        run_period(1'b1, 1'b1, 3, 8);
        chk("post_rst_start", n_start, 1);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_err", n_err, 0);
        chk("post_rst_fcnt", done_f, 1);

        // pixel strobe coinciding with line end
        clear_log();
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        for (int l = 0; l < 3; l++) begin
            coincident_line();
            chk($sformatf("coinc_x%0d", l), x_cnt_o, 0);
            chk($sformatf("coinc_y%0d", l), y_cnt_o, l + 1);
        end
        repeat (4) step(1'b1, 1'b0);
        chk("coinc_start", n_start, 1);
        chk("coinc_done", n_done, 1);
        chk("coinc_err", n_err, 0);
        chk("coinc_done_y", done_y, 3);
        chk("coinc_fcnt", done_f, 2);

        // x counter saturation on an overlong line
        clear_log();
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (4100) raw(1'b0, 1'b1, 1'b1, 1'b1);
        chk("sat_x", x_cnt_o, 4095);
        raw(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_x_clear", x_cnt_o, 0);
        chk("sat_y", y_cnt_o, 1);
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        chk("sat_done", n_done, 1);
        chk("sat_err", n_err, 1);
        chk("sat_done_y", done_y, 1);
        chk("sat_fcnt", done_f, 3);

        // zero-skip instance enabled during VSYNC high
        chk("z_idle_y", y_cnt_z, 0);
        chk("z_idle_busy", busy_z, 0);
        clear_log();
        capture_en0 = 1'b1;
        run_period(1'b1, 1'b1, 3, 8);
        chk("z_start", n_start0, 1);
        chk("z_done", n_done0, 1);
        chk("z_err", n_err0, 0);
        chk("z_done_y", done_y0, 3);
        chk("z_fcnt", done_f0, 1);
        chk("z_busy", busy_z, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
